mpmc11_rd_fifo_arb: RTL and testbench
=====================================

# mpmc11_rd_fifo_arb

Multi-channel read-command FIFO pop generator for the mpmc11 controller. It arbitrates round-robin across NCH per-channel request FIFOs and issues at most one registered one-hot pop (`rd`) per arbitration window while the controller is IDLE and calibration is complete. It enforces a minimum pop spacing, caps the number of in-flight requests, and produces a data-valid strobe aligned to the FIFO read latency. It sits between the per-port command FIFOs and the controller state machine.

## Interface
Parameters:
- `NCH`, 8, number of channel FIFOs (2..16)
- `MAX_OUT`, 4, max popped-but-not-done requests (1..15)
- `RD_LAT`, 1, FIFO read latency in cycles (1..4)
- `HOLD`, 1, HOLD-state cycles after each pop (1..7); pop spacing is HOLD+1 cycles

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `state`  in  mpmc11_state_t  controller state; pops allowed only when IDLE
- `empty`  in  NCH  per-channel FIFO empty
- `rd_rst_busy`  in  NCH  per-channel FIFO reset-busy
- `en`  in  NCH  per-channel enable mask
- `calib_complete`  in  1  memory calibration done
- `done`  in  1  controller retired one popped request
- `rd`  out  NCH  registered one-hot FIFO pop
- `rd_ch`  out  $clog2(NCH)  index of the most recent pop
- `rd_valid`  out  1  FIFO output valid, RD_LAT cycles after `rd`
- `rd_valid_ch`  out  $clog2(NCH)  channel of the `rd_valid` data
- `outstanding`  out  $clog2(MAX_OUT+1)  in-flight count
- `busy`  out  1  outstanding != 0

## Operation
- Eligibility: `elig[i] = en[i] & !empty[i] & !rd_rst_busy[i]`.
- Gate: `calib_complete & state==IDLE & outstanding<MAX_OUT`.
- FSM states:
  - CAL: `rd`=0. Go to ARB on the first cycle `calib_complete`=1.
  - ARB:
    - If gate is true and any channel is eligible, select the first eligible channel searching upward from `ptr` with wrap (NCH-1 -> 0).
    - Register `rd`=onehot(g) and `rd_ch`=g, set `ptr`=(g+1) mod NCH, load `hcnt`=HOLD, go to HOLD.
    - Otherwise `rd`=0 and remain in ARB.
  - HOLD: `rd`=0. Decrement `hcnt` each cycle; go to ARB when it reaches 0.
- `calib_complete`=0 in any state: go to CAL next cycle and force `rd`=0. `outstanding` and the `rd_valid` pipeline are kept.
- `state` != IDLE blocks new grants only. A HOLD countdown already in progress continues.
- Outstanding counter:
  - +1 when `|rd`; −1 when `done`. Both in the same cycle: unchanged.
  - `done` at 0 is ignored; the counter saturates at 0.
  - The gate uses the registered count. A pop is never issued that would push the count past MAX_OUT.
- `rd_valid`/`rd_valid_ch`: a shift pipe of depth RD_LAT fed by `|rd` and `rd_ch`.
- Arithmetic: `ptr` and `rd_ch` are $clog2(NCH) bits. Wrap is explicit, so it is correct for non-power-of-2 NCH.

## Timing
- Reset (asserted asynchronously, released synchronously to `clk`) sets:
  - `rd`=0, `rd_ch`=0, `rd_valid`=0, `rd_valid_ch`=0, `outstanding`=0, `busy`=0
  - FSM=CAL, `ptr`=0, `hcnt`=0
- Pop latency: the eligibility/gate sample at edge N produces `rd` high during cycle N+1, for exactly one cycle.
- HOLD≥1 guarantees the next ARB samples `empty` after the previous pop edge. The FIFO must update `empty` on the pop edge.
- Maximum pop rate: one per HOLD+1 cycles.
- `rd_valid` is high exactly RD_LAT cycles after the corresponding `rd` cycle.
- `busy` and `outstanding` update on the edge after `rd`/`done`.
- From `calib_complete` rising to the first `rd`: 2 cycles (CAL->ARB, ARB->rd).
- Mid-operation `rst_n` low: all outputs clear immediately, without a clock edge. In-flight `rd_valid` pulses are discarded.

## Test plan
- Calibration gating: all `empty`=0, `calib_complete`=0 for 20 cycles -> `rd`=0 throughout. Raise `calib_complete` -> `rd`=8'h01 exactly 2 cycles later, `rd_ch`=0.
- Round robin, HOLD=1: channels 1, 3, 6 non-empty, `done` pulsed after each pop -> `rd` sequence 8'h02, 8'h08, 8'h40, 8'h02 on every second cycle; `rd_ch` sequence 1, 3, 6, 1.
- Outstanding cap, MAX_OUT=4, `done`=0: exactly 4 pops, then stall with `outstanding`=4 and `busy`=1.
  - One `done` -> one further pop.
  - `done` in the same cycle as a pop -> count unchanged.
  - `done` at 0 -> count stays 0.
- Masking: channel 2 `rd_rst_busy`=1 and channel 5 `en`=0, both non-empty -> never popped.
  - `state` != IDLE for 10 cycles -> no `rd`.
  - Return to IDLE -> pop within 2 cycles.
- Latency, RD_LAT=3: pop of channel 4 -> `rd_valid`=1 with `rd_valid_ch`=4 exactly 3 cycles after `rd`.
- Async reset: `rst_n` low mid-HOLD with `outstanding`=2 and a `rd_valid` pending -> all outputs 0 before the next edge. After release, FSM is in CAL.

Source files
------------

// File: rtl/mpmc11_rd_fifo_arb.sv
// mpmc11 read-command FIFO pop generator.
// Round-robin arbiter over NCH per-channel command FIFOs. It issues at most
// one registered one-hot pop per arbitration window, spaces pops by HOLD+1
// cycles, caps in-flight requests at MAX_OUT, and delays a data-valid strobe
// by the FIFO read latency.

package mpmc11_pkg;
  // Controller state as seen by the read-side arbiter; pops only in IDLE.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACTIVATE  = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    PRECHARGE = 3'd4,
    REFRESH   = 3'd5
  } mpmc11_state_t;
endpackage

module mpmc11_rd_fifo_arb
  import mpmc11_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int MAX_OUT = 4,
  parameter int RD_LAT  = 1,
  parameter int HOLD    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  mpmc11_state_t                state,
  input  logic [NCH-1:0]               empty,
  input  logic [NCH-1:0]               rd_rst_busy,
  input  logic [NCH-1:0]               en,
  input  logic                         calib_complete,
  input  logic                         done,
  output logic [NCH-1:0]               rd,
  output logic [$clog2(NCH)-1:0]       rd_ch,
  output logic                         rd_valid,
  output logic [$clog2(NCH)-1:0]       rd_valid_ch,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         busy
);

  localparam int CW = $clog2(NCH);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int HW = 3;

  localparam logic [1:0] S_CAL  = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [NCH-1:0] ONEHOT_LSB = NCH'(1);

  logic [1:0]     r_fsm;
  logic [CW-1:0]  r_ptr;
  logic [HW-1:0]  r_hcnt;
  logic [NCH-1:0] r_rd;
  logic [CW-1:0]  r_rd_ch;
  logic [OW-1:0]  r_out;
  logic           r_vpipe [RD_LAT];
  logic [CW-1:0]  r_cpipe [RD_LAT];

  logic [NCH-1:0] w_elig;
  logic           w_gate;
  logic           w_any;
  logic [CW-1:0]  w_gnt;
  logic [CW-1:0]  w_ptr_nxt;
  logic           w_inc;
  logic           w_dec;

  assign w_elig = en & ~empty & ~rd_rst_busy;
  assign w_gate = calib_complete && (state == IDLE) && (r_out < OW'(MAX_OUT));

  // Round-robin search: first eligible channel at or above r_ptr, wrapping
  // explicitly so non-power-of-2 NCH works.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_any && w_elig[idx]) begin
        w_any = 1'b1;
        w_gnt = CW'(idx);
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == CW'(NCH-1)) ? '0 : w_gnt + CW'(1);

  // Arbitration FSM: CAL -> ARB -> (pop) HOLD x HOLD cycles -> ARB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_CAL;
      r_ptr   <= '0;
      r_hcnt  <= '0;
      r_rd    <= '0;
      r_rd_ch <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the default below makes rd a one-cycle pulse.
      r_rd <= '0;
      if (!calib_complete) begin
        r_fsm <= S_CAL;
      end else begin
        case (r_fsm)
          S_CAL: r_fsm <= S_ARB;
          S_ARB: begin
            if (w_gate && w_any) begin
              r_rd    <= ONEHOT_LSB << w_gnt;
              r_rd_ch <= w_gnt;
              r_ptr   <= w_ptr_nxt;
              r_hcnt  <= HW'(HOLD);
              r_fsm   <= S_HOLD;
            end
          end
          S_HOLD: begin
            // The HOLD countdown is not gated by the controller state.
            r_hcnt <= (r_hcnt != '0) ? r_hcnt - HW'(1) : '0;
            if (r_hcnt <= HW'(1)) r_fsm <= S_ARB;
          end
          default: r_fsm <= S_CAL;
        endcase
      end
    end
  end

  assign w_inc = |r_rd;
  assign w_dec = done && (r_out != '0);

  // In-flight counter: pop increments, done decrements, both cancel; the
  // arbiter gate keeps it from ever exceeding MAX_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_inc && !done) begin
      r_out <= r_out + OW'(1);
    end else if (!w_inc && w_dec) begin
      r_out <= r_out - OW'(1);
    end
  end

  // Data-valid pipe aligned to the FIFO read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small array is reset on purpose: a reset must discard any
      // pending valid strobes, unlike a data RAM whose contents are don't-care.
      for (int i = 0; i < RD_LAT; i++) begin
        r_vpipe[i] <= 1'b0;
        r_cpipe[i] <= '0;
      end
    end else begin
      r_vpipe[0] <= |r_rd;
      r_cpipe[0] <= r_rd_ch;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_cpipe[i] <= r_cpipe[i-1];
      end
    end
  end

  assign rd          = r_rd;
  assign rd_ch       = r_rd_ch;
  assign rd_valid    = r_vpipe[RD_LAT-1];
  assign rd_valid_ch = r_cpipe[RD_LAT-1];
  assign outstanding = r_out;
  assign busy        = (r_out != '0);

endmodule

// File: tb/tb_mpmc11_rd_fifo_arb.sv
// Self-checking bench for mpmc11_rd_fifo_arb: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a time-based
// reference model (grant allowed once "now >= next allowed arbitration time").
module tb_mpmc11_rd_fifo_arb;
  import mpmc11_pkg::*;

  localparam int NCH     = 8;
  localparam int MAX_OUT = 4;
  localparam int RD_LAT  = 3;
  localparam int HOLD    = 1;
  localparam int CW      = $clog2(NCH);
  localparam int OW      = $clog2(MAX_OUT+1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  mpmc11_state_t  state = IDLE;
  logic [NCH-1:0] empty = '1;
  logic [NCH-1:0] rd_rst_busy = '0;
  logic [NCH-1:0] en = '1;
  logic           calib_complete = 1'b0;
  logic           done = 1'b0;
  logic [NCH-1:0] rd;
  logic [CW-1:0]  rd_ch;
  logic           rd_valid;
  logic [CW-1:0]  rd_valid_ch;
  logic [OW-1:0]  outstanding;
  logic           busy;

  mpmc11_rd_fifo_arb #(
    .NCH(NCH), .MAX_OUT(MAX_OUT), .RD_LAT(RD_LAT), .HOLD(HOLD)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .state(state), .empty(empty),
    .rd_rst_busy(rd_rst_busy), .en(en), .calib_complete(calib_complete),
    .done(done), .rd(rd), .rd_ch(rd_ch), .rd_valid(rd_valid),
    .rd_valid_ch(rd_valid_ch), .outstanding(outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int ch; } vld_t;
  vld_t m_vq[$];
  int   m_active;    // 0 = waiting for calibration, 1 = arbitrating/holding
  int   m_next_arb;  // earliest cycle whose closing edge may grant
  int   m_last;      // last granted channel (search starts one above it)
  int   m_rd;        // channel popped in the current cycle, -1 if none
  int   m_rd_ch;
  int   m_out;
  int   cyc = 0;

  task automatic model_reset();
    m_active   = 0;
    m_next_arb = 0;
    m_last     = NCH - 1;
    m_rd       = -1;
    m_rd_ch    = 0;
    m_out      = 0;
    m_vq.delete();
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    logic [NCH-1:0] exp_rd;
    logic           exp_v;
    exp_rd = '0;
    if (m_rd >= 0) exp_rd[m_rd] = 1'b1;
    check("rd", rd, exp_rd);
    check("rd_ch", rd_ch, m_rd_ch);
    check("outstanding", outstanding, m_out);
    check("busy", busy, m_out != 0);
    while (m_vq.size() != 0 && m_vq[0].cyc < cyc) void'(m_vq.pop_front());
    exp_v = (m_vq.size() != 0) && (m_vq[0].cyc == cyc);
    check("rd_valid", rd_valid, exp_v);
    if (exp_v) check("rd_valid_ch", rd_valid_ch, m_vq[0].ch);
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_edge();
    logic [NCH-1:0] elig;
    int             new_rd;
    vld_t           v;
    elig   = en & ~empty & ~rd_rst_busy;
    new_rd = -1;
    if (m_rd >= 0) begin
      v.cyc = cyc + RD_LAT;
      v.ch  = m_rd;
      m_vq.push_back(v);
    end
    if (!calib_complete) begin
      m_active = 0;
    end else if (m_active == 0) begin
      m_active   = 1;
      m_next_arb = cyc + 1;
    end else if (cyc >= m_next_arb && state == IDLE && m_out < MAX_OUT && elig != '0) begin
      for (int k = 1; k <= NCH; k++) begin
        if (new_rd < 0 && elig[(m_last + k) % NCH]) new_rd = (m_last + k) % NCH;
      end
      m_last     = new_rd;
      m_rd_ch    = new_rd;
      m_next_arb = cyc + HOLD + 1;
    end
    if (m_rd >= 0 && !done) m_out++;
    else if (m_rd < 0 && done && m_out > 0) m_out--;
    m_rd = new_rd;
    cyc++;
  endtask

  // One clock cycle: check outputs, drive the next inputs, advance the model.
  task automatic step(input logic cal, input mpmc11_state_t st, input logic [NCH-1:0] emp,
                      input logic [NCH-1:0] rb, input logic [NCH-1:0] ena, input logic dn);
    @(negedge clk);
    check_outputs();
    calib_complete = cal;
    state          = st;
    empty          = emp;
    rd_rst_busy    = rb;
    en             = ena;
    done           = dn;
    model_edge();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops[$];
    int found;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", rd, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_busy", busy, 0);
    #1 rst_n = 1'b1;

    // Calibration gating: all FIFOs non-empty, calibration low for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, IDLE, '0, '0, '1, 1'b0);
      check("cal_gate_rd", rd, 0);
    end
    step(1'b1, IDLE, '0, '0, '1, 1'b0);
    step(1'b1, IDLE, '0, '0, '1, 1'b0);
    check("cal_no_rd_yet", rd, 0);
    step(1'b1, IDLE, 8'b1011_0101, '0, '1, 1'b0);
    check("cal_first_rd", rd, 8'h01);
    check("cal_first_rd_ch", rd_ch, 0);

    // Round robin over channels 1, 3, 6 with done after each pop.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, IDLE, 8'b1011_0101, '0, '1, m_out > 0);
      if (rd != '0) pops.push_back(int'(rd_ch));
    end
    check("rr_pop_count", pops.size(), 4);
    if (pops.size() >= 4) begin
      check("rr_pop0", pops[0], 1);
      check("rr_pop1", pops[1], 3);
      check("rr_pop2", pops[2], 6);
      check("rr_pop3", pops[3], 1);
    end

    // Outstanding cap: no done, all eligible.
    for (int i = 0; i < 16; i++) step(1'b1, IDLE, '0, '0, '1, 1'b0);
    check("cap_outstanding", outstanding, MAX_OUT);
    check("cap_busy", busy, 1);
    step(1'b1, IDLE, '0, '0, '1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      // A done in the cycle of the refill pop leaves the count unchanged.
      step(1'b1, IDLE, '0, '0, '1, m_rd >= 0 && m_out == MAX_OUT - 1);
    end
    // Drain to zero with nothing eligible, then done at zero.
    for (int i = 0; i < 8; i++) step(1'b1, IDLE, '1, '0, '1, m_out > 0);
    for (int i = 0; i < 3; i++) step(1'b1, IDLE, '1, '0, '1, 1'b1);
    check("done_at_zero", outstanding, 0);

    // Masking: channel 2 reset-busy, channel 5 disabled, both non-empty.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDLE, 8'b1101_1011, 8'b0000_0100, 8'b1101_1111, 1'b0);
      check("mask_rd", rd, 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, READ, 8'b1101_1010, 8'b0000_0100, 8'b1101_1111, 1'b0);
      check("not_idle_rd", rd, 0);
    end
    step(1'b1, IDLE, 8'b1101_1010, 8'b0000_0100, 8'b1101_1111, 1'b0);
    step(1'b1, IDLE, 8'b1101_1010, 8'b0000_0100, 8'b1101_1111, 1'b0);
    check("idle_return_rd", rd, 8'h01);

    // Latency: only channel 4 eligible; rd_valid exactly RD_LAT cycles later.
    for (int i = 0; i < 8; i++) step(1'b1, IDLE, '1, '0, '1, m_out > 0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step(1'b1, IDLE, 8'b1110_1111, '0, '1, 1'b0);
      if (rd[4]) found = 1;
    end
    check("lat_pop_seen", found, 1);
    if (found == 1) begin
      for (int i = 0; i < RD_LAT; i++) step(1'b1, IDLE, '1, '0, '1, 1'b0);
      check("lat_rd_valid", rd_valid, 1);
      check("lat_rd_valid_ch", rd_valid_ch, 4);
    end
    for (int i = 0; i < 8; i++) step(1'b1, IDLE, '1, '0, '1, m_out > 0);

    // Async reset mid-HOLD with outstanding=2 and a valid strobe pending.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1'b1, IDLE, '0, '0, '1, 1'b0);
      if (m_rd >= 0 && m_out == 2) found = 1;
    end
    check("rst_setup", found, 1);
    @(negedge clk);
    check_outputs();
    #1 rst_n = 1'b0;
    #1;
    check("arst_rd", rd, 0);
    check("arst_rd_ch", rd_ch, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_valid_ch", rd_valid_ch, 0);
    check("arst_outstanding", outstanding, 0);
    check("arst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    // After release the arbiter restarts from calibration wait.
    step(1'b1, IDLE, '0, '0, '1, 1'b0);
    step(1'b1, IDLE, '0, '0, '1, 1'b0);
    check("post_rst_no_rd", rd, 0);
    step(1'b1, IDLE, '0, '0, '1, 1'b0);
    check("post_rst_first_rd", rd, 8'h01);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic           r_cal;
      mpmc11_state_t  r_st;
      r_cal = ($urandom_range(0, 49) != 0);
      r_st  = ($urandom_range(0, 4) == 0) ? mpmc11_state_t'($urandom_range(1, 5)) : IDLE;
      step(r_cal, r_st, NCH'($urandom | $urandom), NCH'($urandom & $urandom & $urandom),
           NCH'(~($urandom & $urandom)), (m_out > 0) && ($urandom_range(0, 2) == 0));
    end
    @(negedge clk);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
